// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared constants and state type for the AES-128 key schedule sequencer
//
// Purpose: round count, key width and round-index width used by
// aes_key_sched_ctrl, plus the sequencer state enumeration.
// Ports: none (package).

package aes_ctrl_pkg;

    localparam int AES_NUM_ROUNDS  = 10;
    localparam int AES_KEY_W       = 128;
    localparam int AES_ROUND_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        STEP    = 2'd2
    } key_sched_state_t;

endpackage

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequencer presenting AES-128 round keys 0..10 over valid/ready
//
// Purpose: latches a cipher key on startKey, steps an external round-key
// generator one round at a time and presents each round key to a single
// consumer, stalling the generator while the consumer is not ready.
//
// Ports:
//   pClk, sRst          clock, synchronous active-high reset
//   startKey, aesKeyIn  start request and the key sampled when it is accepted
//   abort               cancels an expansion in progress (no done pulse)
//   keyGen*             enable/loadKey/roundCount/aesKey to the generator,
//                       keyGenRoundKey back from it
//   roundKey*           valid/ready handshake, index and data to the consumer
//   busy, done          expansion in progress, one-cycle completion pulse
//
// Optional build macro AES_KEY_SCHED_LAST_KEY_EN adds lastRoundKey and
// lastRoundKeyValid, holding round key 10 (the decryption start key).

module aes_key_sched_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic                       pClk,
    input  logic                       sRst,
    input  logic                       startKey,
    input  logic                       abort,
    input  logic [KEY_W-1:0]           aesKeyIn,
    output logic                       keyGenEnable,
    output logic                       keyGenLoadKey,
    output logic [AES_ROUND_IDX_W-1:0] keyGenRoundCount,
    output logic [KEY_W-1:0]           keyGenKey,
    input  logic [KEY_W-1:0]           keyGenRoundKey,
    output logic                       roundKeyValid,
    input  logic                       roundKeyReady,
    output logic [AES_ROUND_IDX_W-1:0] roundKeyIdx,
    output logic [KEY_W-1:0]           roundKeyOut,
    output logic                       busy,
    output logic                       done
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    ,
    output logic [KEY_W-1:0]           lastRoundKey,
    output logic                       lastRoundKeyValid
`endif
);

    key_sched_state_t           state;
    key_sched_state_t           state_next;
    logic [AES_ROUND_IDX_W-1:0] idx;
    logic [KEY_W-1:0]           keyReg;

    logic accept_start;
    logic last_round;
    logic final_accept;

    localparam logic [AES_ROUND_IDX_W-1:0] LAST_IDX = AES_ROUND_IDX_W'(NUM_ROUNDS);

    // startKey is only honoured from IDLE; a simultaneous abort cancels it.
    assign accept_start = (state == IDLE) && startKey && !abort;
    assign last_round   = (idx == LAST_IDX);
    // Abort beats the final handshake, so no done and no last-key capture.
    assign final_accept = (state == PRESENT) && roundKeyReady && !abort && last_round;

    assign busy        = (state != IDLE);
    assign keyGenKey   = keyReg;
    assign roundKeyIdx = idx;
    // Round 0 is the cipher key itself; later rounds come from the generator
    // register, which only moves in STEP and so is stable while presenting.
    assign roundKeyOut = (idx == '0) ? keyReg : keyGenRoundKey;

    always_comb begin
        state_next       = state;
        keyGenEnable     = 1'b0;
        keyGenLoadKey    = 1'b0;
        keyGenRoundCount = '0;
        roundKeyValid    = 1'b0;
        case (state)
            IDLE: begin
                if (accept_start) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                roundKeyValid = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (roundKeyReady) begin
                    state_next = last_round ? IDLE : STEP;
                end
            end
            STEP: begin
                keyGenEnable     = 1'b1;
                keyGenLoadKey    = (idx == '0);
                keyGenRoundCount = idx;
                state_next       = abort ? IDLE : PRESENT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pClk) begin
        if (sRst) begin
            state  <= IDLE;
            idx    <= '0;
            keyReg <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= final_accept;
            if (accept_start) begin
                keyReg <= aesKeyIn;
                idx    <= '0;
            end else if ((state == STEP) && !abort) begin
                // STEP is only entered below the last round, so idx tops out at NUM_ROUNDS.
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef AES_KEY_SCHED_LAST_KEY_EN
    always_ff @(posedge pClk) begin
        if (sRst || accept_start) begin
            lastRoundKey      <= '0;
            lastRoundKeyValid <= 1'b0;
        end else if (final_accept) begin
            lastRoundKey      <= roundKeyOut;
            lastRoundKeyValid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl with an AES-128 generator model

module tb_aes_key_sched_ctrl;

    logic         pClk = 1'b0;
    logic         sRst;
    logic         startKey;
    logic         abort;
    logic [127:0] aesKeyIn;
    logic         keyGenEnable;
    logic         keyGenLoadKey;
    logic [3:0]   keyGenRoundCount;
    logic [127:0] keyGenKey;
    logic [127:0] keyGenRoundKey;
    logic         roundKeyValid;
    logic         roundKeyReady;
    logic [3:0]   roundKeyIdx;
    logic [127:0] roundKeyOut;
    logic         busy;
    logic         done;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    logic [127:0] lastRoundKey;
    logic         lastRoundKeyValid;
`endif

    aes_key_sched_ctrl dut (
        .pClk             (pClk),
        .sRst             (sRst),
        .startKey         (startKey),
        .abort            (abort),
        .aesKeyIn         (aesKeyIn),
        .keyGenEnable     (keyGenEnable),
        .keyGenLoadKey    (keyGenLoadKey),
        .keyGenRoundCount (keyGenRoundCount),
        .keyGenKey        (keyGenKey),
        .keyGenRoundKey   (keyGenRoundKey),
        .roundKeyValid    (roundKeyValid),
        .roundKeyReady    (roundKeyReady),
        .roundKeyIdx      (roundKeyIdx),
        .roundKeyOut      (roundKeyOut),
        .busy             (busy),
        .done             (done)
`ifdef AES_KEY_SCHED_LAST_KEY_EN
        ,
        .lastRoundKey     (lastRoundKey),
        .lastRoundKeyValid(lastRoundKeyValid)
`endif
    );

    always #5 pClk = ~pClk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // AES arithmetic: S-box derived from GF(2^8) inverse plus affine map.
    logic [7:0] sb [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // External generator: register stepped by enable, seeded from aesKey on loadKey.
    function automatic logic [127:0] gen_next(input logic [127:0] prev, input logic [3:0] rnd);
        logic [31:0] t, n0, n1, n2, n3;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < int'(rnd); i++) rc = xtime(rc);
        t  = prev[31:0];
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = prev[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] gen_key = '0;
    assign keyGenRoundKey = gen_key;
    always @(posedge pClk) begin
        if (keyGenEnable === 1'b1)
            gen_key <= gen_next(keyGenLoadKey ? keyGenKey : gen_key, keyGenRoundCount);
    end

    // Reference: word-wise FIPS-197 expansion into all eleven round keys.
    logic [127:0] rk [11];

    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Scoreboard shared between driver and monitor.
    bit           mon_en = 0;
    int           exp_idx = 0;
    int           hs_count = 0;
    int           ld_cnt = 0;
    bit           exp_done = 0;
    bit           stall = 0;
    logic [3:0]   st_idx;
    logic [127:0] st_data;

    initial begin
        forever begin
            @(negedge pClk);
            if (mon_en) begin
                check("done_pulse", 128'(done), 128'(exp_done));
                check("busy_decode", 128'(busy), 128'(roundKeyValid | keyGenEnable));
                check("valid_en_excl", 128'(roundKeyValid & keyGenEnable), 128'(0));
                if (!keyGenEnable)
                    check("gen_quiet", 128'({keyGenLoadKey, keyGenRoundCount}), 128'(0));
                if (stall && roundKeyValid) begin
                    check("hold_idx", 128'(roundKeyIdx), 128'(st_idx));
                    check("hold_data", roundKeyOut, st_data);
                end
                exp_done = 0;
                stall    = 0;
                if (keyGenLoadKey) ld_cnt++;
                if (keyGenEnable) begin
                    check("step_round", 128'(keyGenRoundCount), 128'(exp_idx - 1));
                    check("step_load", 128'(keyGenLoadKey), 128'(exp_idx == 1));
                end
                if (roundKeyValid && !sRst && !abort) begin
                    if (roundKeyReady) begin
                        if (exp_idx > 10) begin
                            check("hs_overrun", 128'(exp_idx), 128'(10));
                        end else begin
                            check("hs_idx", 128'(roundKeyIdx), 128'(exp_idx));
                            check("hs_data", roundKeyOut, rk[exp_idx]);
                            exp_done = (exp_idx == 10);
                        end
                        exp_idx++;
                        hs_count++;
                    end else begin
                        stall   = 1;
                        st_idx  = roundKeyIdx;
                        st_data = roundKeyOut;
                    end
                end
            end
        end
    end

    // ev: 0 none, 1 backpressure at ev_idx, 2 abort in STEP of ev_idx,
    //     3 startKey while busy at ev_idx, 4 reset at ev_idx, 5 abort on final handshake
    task automatic run_expansion(input logic [127:0] key, input bit rnd_ready,
                                 input int ev, input int ev_idx, input bit fips);
        int cyc, hold, post;
        bit fired, fin;
        cyc = 0; hold = 0; post = 0; fired = 0; fin = 0;
        build_ref(key);
        exp_idx  = 0;
        hs_count = 0;
        ld_cnt   = 0;
        startKey = 1'b1;
        aesKeyIn = key;
        abort    = 1'b0;
        sRst     = 1'b0;
        roundKeyReady = 1'b1;
        for (int n = 0; n < 300 && !fin; n++) begin
            @(posedge pClk); #1;
            cyc++;
            startKey = 1'b0;
            abort    = 1'b0;
            sRst     = 1'b0;
            aesKeyIn = key;
            roundKeyReady = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (cyc == 1) begin
                check("start_valid", 128'(roundKeyValid), 128'(1));
                check("start_idx", 128'(roundKeyIdx), 128'(0));
                check("start_data", roundKeyOut, key);
`ifdef AES_KEY_SCHED_LAST_KEY_EN
                check("last_cleared", 128'(lastRoundKeyValid), 128'(0));
`endif
            end
            if (!rnd_ready && ev == 0 && roundKeyValid)
                check("latency", 128'(cyc), 128'(2 * int'(roundKeyIdx) + 1));
            if (fips && roundKeyValid && roundKeyIdx == 4'd1)
                check("fips_r1", roundKeyOut, 128'ha0fafe1788542cb123a339392a6c7605);
            if (fips && roundKeyValid && roundKeyIdx == 4'd10)
                check("fips_r10", roundKeyOut, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            case (ev)
                1: if (roundKeyValid && roundKeyIdx == 4'(ev_idx) && hold < 5) begin
                       roundKeyReady = 1'b0;
                       hold++;
                       check("bp_no_enable", 128'(keyGenEnable), 128'(0));
                   end
                2, 4, 5: if (fired) begin
                       post++;
                       if (post == 1) begin
                           check("stop_busy", 128'(busy), 128'(0));
                           check("stop_valid", 128'(roundKeyValid), 128'(0));
                           if (ev == 4)
                               check("rst_outputs", 128'({done, keyGenEnable, keyGenLoadKey, keyGenRoundCount}), 128'(0));
`ifdef AES_KEY_SCHED_LAST_KEY_EN
                           check("stop_last_valid", 128'(lastRoundKeyValid), 128'(0));
`endif
                       end
                       if (ev == 4 || post == 4) fin = 1;
                   end else if (ev == 2 && keyGenEnable && keyGenRoundCount == 4'(ev_idx)) begin
                       abort = 1'b1; fired = 1;
                   end else if (ev == 4 && roundKeyValid && roundKeyIdx == 4'(ev_idx)) begin
                       sRst = 1'b1; fired = 1;
                   end else if (ev == 5 && roundKeyValid && roundKeyIdx == 4'd10) begin
                       abort = 1'b1; roundKeyReady = 1'b1; fired = 1;
                   end
                3: if (!fired && roundKeyValid && roundKeyIdx == 4'(ev_idx)) begin
                       startKey = 1'b1;
                       aesKeyIn = ~key;
                       fired = 1;
                   end
                default: ;
            endcase
            if (done && !fin) begin
                if (!rnd_ready && ev == 0) check("done_cycle", 128'(cyc), 128'(22));
                check("hs_total", 128'(hs_count), 128'(11));
                check("loadkey_once", 128'(ld_cnt), 128'(1));
                if (ev == 1) check("bp_cycles", 128'(hold), 128'(5));
                if (ev == 3) check("key_unchanged", keyGenKey, key);
`ifdef AES_KEY_SCHED_LAST_KEY_EN
                check("last_valid", 128'(lastRoundKeyValid), 128'(1));
                check("last_key", lastRoundKey, rk[10]);
                if (fips) check("last_key_fips", lastRoundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
                fin = 1;
            end
        end
        if (!fin) check("timeout", 128'(0), 128'(1));
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        sRst = 1'b1; startKey = 1'b0; abort = 1'b0; aesKeyIn = '0; roundKeyReady = 1'b0;
        repeat (3) @(posedge pClk);
        #1;
        check("rst_valid", 128'(roundKeyValid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_gen", 128'({keyGenEnable, keyGenLoadKey, keyGenRoundCount}), 128'(0));
        check("rst_key", keyGenKey, 128'(0));
        check("rst_idx", 128'(roundKeyIdx), 128'(0));
        sRst = 1'b0;
        mon_en = 1;
        @(posedge pClk); #1;

        run_expansion(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 0, 1);
        run_expansion(rand_key(), 0, 1, 3, 0);
        run_expansion(rand_key(), 0, 2, 6, 0);
        run_expansion(rand_key(), 0, 0, 0, 0);
        run_expansion(rand_key(), 0, 3, 4, 0);
        run_expansion(rand_key(), 0, 4, 7, 0);
        run_expansion(rand_key(), 0, 0, 0, 0);
        run_expansion(rand_key(), 0, 5, 10, 0);
        run_expansion(rand_key(), 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) run_expansion(rand_key(), 1, 0, 0, 0);

        @(posedge pClk); #1;
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
